// File: rtl/ft_host_pkg.sv
// Shared definitions for the FT245 host link master.
// Holds packet ID bytes, command and status codes, the TX/RX state encodings
// and a helper that picks one byte of a 32-bit word, MSB first.
package ft_host_pkg;

    localparam logic [7:0] ID_REQ_DEF = 8'hCD;
    localparam logic [7:0] ID_RSP_DEF = 8'hDC;

    localparam logic [7:0] CMD_PING  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    // Low nibble of the response status word.
    localparam logic [3:0] ST_DONE  = 4'hF;  // header-only response
    localparam logic [3:0] ST_WACK  = 4'hE;  // write acknowledge, carries address
    localparam logic [3:0] ST_RDATA = 4'hD;  // read response, carries address + data

    typedef enum logic [2:0] {
        T_IDLE, T_ID, T_CMD, T_ADDR, T_DATA, T_WAIT
    } tx_state_e;

    typedef enum logic [2:0] {
        R_IDLE, R_STATUS, R_ADDR, R_DATA, R_DROP
    } rx_state_e;

    // idx 0 selects bits [31:24], idx 3 selects bits [7:0].
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/ft_host_rsp_parser.sv
// Response parser (RX FSM) for the FT245 host link master.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   abort_i             timeout abort: return to R_IDLE, drop held data
//   busy_i              a request is outstanding (responses accepted only then)
//   data_count_i        word count latched from the outstanding request
//   rx_data_i/valid/ready  byte stream from the link
//   rsp_valid_o, rsp_status_o, rsp_address_o  one-cycle header pulse + fields
//   rd_data_o/valid/ready  read-data words
//   err_bad_id_o        one-cycle pulse for a non-ID byte in R_IDLE
//   done_o              combinational completion strobe for the top
module ft_host_rsp_parser
    import ft_host_pkg::*;
#(
    parameter logic [7:0] ID_RSP = ID_RSP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        abort_i,
    input  logic        busy_i,
    input  logic [23:0] data_count_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_status_o,
    output logic [31:0] rsp_address_o,
    output logic [31:0] rd_data_o,
    output logic        rd_data_valid_o,
    input  logic        rd_data_ready_i,
    output logic        err_bad_id_o,
    output logic        done_o
);

    rx_state_e   state_q, state_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        drop_ph_q, drop_ph_d;   // 0: dropping status, 1: dropping address
    logic [23:0] sh_q, sh_d;             // first three bytes of the current field
    logic [31:0] status_q, status_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_vld_q, rd_vld_d;
    logic [23:0] wcnt_q, wcnt_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic        bad_id_q, bad_id_d;
    logic        up_q;                   // keeps rx_ready low while in reset
    logic        done_c;
    logic        rx_fire, rd_fire;
    logic [31:0] word_c;

    // Backpressure the link only while a finished word is waiting on the consumer.
    assign rx_ready_o = up_q && !(state_q == R_DATA && rd_vld_q && !rd_data_ready_i);
    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign rd_fire    = rd_vld_q && rd_data_ready_i;
    assign word_c     = {sh_q, rx_data_i};

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        drop_ph_d = drop_ph_q;
        sh_d      = sh_q;
        status_d  = status_q;
        addr_d    = addr_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = rd_vld_q;
        wcnt_d    = wcnt_q;
        rsp_vld_d = 1'b0;
        bad_id_d  = 1'b0;
        done_c    = 1'b0;

        if (rd_fire) rd_vld_d = 1'b0;
        if (rx_fire) sh_d = word_c[23:0];

        case (state_q)
            R_IDLE: begin
                if (rx_fire) begin
                    bcnt_d    = 2'd0;
                    drop_ph_d = 1'b0;
                    if (rx_data_i == ID_RSP)
                        state_d = busy_i ? R_STATUS : R_DROP;
                    else
                        bad_id_d = 1'b1;
                end
            end
            R_STATUS: begin
                if (rx_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        status_d = word_c;
                        if (word_c[3:0] == ST_DONE) begin
                            rsp_vld_d = 1'b1;
                            done_c    = 1'b1;
                            state_d   = R_IDLE;
                        end else begin
                            state_d = R_ADDR;
                        end
                    end
                end
            end
            R_ADDR: begin
                if (rx_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        addr_d    = word_c;
                        rsp_vld_d = 1'b1;
                        if (status_q[3:0] == ST_RDATA && data_count_i != 24'd0) begin
                            state_d = R_DATA;
                            wcnt_d  = 24'd0;
                        end else begin
                            done_c  = 1'b1;
                            state_d = R_IDLE;
                        end
                    end
                end
            end
            R_DATA: begin
                if (rx_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        rd_data_d = word_c;
                        rd_vld_d  = 1'b1;
                    end
                end
                if (rd_fire) begin
                    wcnt_d = wcnt_q + 24'd1;
                    if (wcnt_q == data_count_i - 24'd1) begin
                        done_c  = 1'b1;
                        state_d = R_IDLE;
                    end
                end
            end
            R_DROP: begin
                // Unsolicited packet: consume status (and address unless the
                // status says header-only), publish nothing.
                if (rx_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (drop_ph_q || rx_data_i[3:0] == ST_DONE)
                            state_d = R_IDLE;
                        else
                            drop_ph_d = 1'b1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase

        if (abort_i) begin
            state_d  = R_IDLE;
            bcnt_d   = 2'd0;
            rd_vld_d = 1'b0;
            done_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= R_IDLE;
            bcnt_q    <= 2'd0;
            drop_ph_q <= 1'b0;
            sh_q      <= 24'd0;
            status_q  <= 32'd0;
            addr_q    <= 32'd0;
            rd_data_q <= 32'd0;
            rd_vld_q  <= 1'b0;
            wcnt_q    <= 24'd0;
            rsp_vld_q <= 1'b0;
            bad_id_q  <= 1'b0;
            up_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            drop_ph_q <= drop_ph_d;
            sh_q      <= sh_d;
            status_q  <= status_d;
            addr_q    <= addr_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            wcnt_q    <= wcnt_d;
            rsp_vld_q <= rsp_vld_d;
            bad_id_q  <= bad_id_d;
            up_q      <= 1'b1;
        end
    end

    assign rsp_valid_o     = rsp_vld_q;
    assign rsp_status_o    = status_q;
    assign rsp_address_o   = addr_q;
    assign rd_data_o       = rd_data_q;
    assign rd_data_valid_o = rd_vld_q;
    assign err_bad_id_o    = bad_id_q;
    assign done_o          = done_c;

endmodule

// File: rtl/ft_host_link_master.sv
// FT245 host link master: serialises one request at a time into a byte
// packet (ID, command, count, address, write data) and parses the response.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_*                        request handshake + command/address/count
//   wr_data/valid/ready          write-data words (one per 4 data bytes)
//   tx_data/valid/ready          bytes toward the link
//   rx_data/valid/ready          bytes from the link
//   rsp_valid/status/address     response header pulse
//   rd_data/valid/ready          read-data words
//   err_bad_id, err_timeout      single-cycle error pulses
//   busy                         transaction outstanding
module ft_host_link_master
    import ft_host_pkg::*;
#(
    parameter logic [7:0]  ID_REQ      = 8'hCD,
    parameter logic [7:0]  ID_RSP      = 8'hDC,
    parameter logic [31:0] RSP_TIMEOUT = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_command,
    input  logic [31:0] req_address,
    input  logic [23:0] req_data_count,
    input  logic [31:0] wr_data,
    input  logic        wr_data_valid,
    output logic        wr_data_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_status,
    output logic [31:0] rsp_address,
    output logic [31:0] rd_data,
    output logic        rd_data_valid,
    input  logic        rd_data_ready,
    output logic        err_bad_id,
    output logic        err_timeout,
    output logic        busy
);

    tx_state_e   tx_q, tx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] wcnt_q, wcnt_d;
    logic [31:0] word_q, word_d;
    logic        word_vld_q, word_vld_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [23:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        err_to_q;

    logic        done, complete, timeout_hit, accept;
    logic        tx_fire, wr_fire, rx_fire;
    logic [7:0]  cmd_norm;

    ft_host_rsp_parser #(.ID_RSP(ID_RSP)) u_parser (
        .clk             (clk),
        .rst             (rst),
        .abort_i         (timeout_hit),
        .busy_i          (busy_q),
        .data_count_i    (cnt_q),
        .rx_data_i       (rx_data),
        .rx_valid_i      (rx_valid),
        .rx_ready_o      (rx_ready),
        .rsp_valid_o     (rsp_valid),
        .rsp_status_o    (rsp_status),
        .rsp_address_o   (rsp_address),
        .rd_data_o       (rd_data),
        .rd_data_valid_o (rd_data_valid),
        .rd_data_ready_i (rd_data_ready),
        .err_bad_id_o    (err_bad_id),
        .done_o          (done)
    );

    // Unknown commands go out as pings.
    assign cmd_norm = (req_command == CMD_WRITE || req_command == CMD_READ) ? req_command : CMD_PING;

    assign req_ready   = ~busy_q;
    assign busy        = busy_q;
    assign err_timeout = err_to_q;
    assign complete    = done && busy_q;
    // Completion always beats an incoming request in the same cycle.
    assign accept      = req_valid && !busy_q && !complete;
    assign rx_fire     = rx_valid && rx_ready;
    assign timeout_hit = (tx_q == T_WAIT) && !rx_fire && !complete &&
                         (to_cnt_q == RSP_TIMEOUT - 32'd1);

    // Write words are buffered so tx_data stays stable while tx_ready stalls.
    assign wr_data_ready = (tx_q == T_DATA) && !word_vld_q;
    assign wr_fire       = wr_data_ready && wr_data_valid;

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (tx_q)
            T_ID: begin
                tx_valid = 1'b1;
                tx_data  = ID_REQ;
            end
            T_CMD: begin
                tx_valid = 1'b1;
                tx_data  = (bcnt_q == 2'd0) ? cmd_q : byte_sel({8'h00, cnt_q}, bcnt_q);
            end
            T_ADDR: begin
                tx_valid = 1'b1;
                tx_data  = byte_sel(addr_q, bcnt_q);
            end
            T_DATA: begin
                tx_valid = word_vld_q;
                tx_data  = word_vld_q ? byte_sel(word_q, bcnt_q) : 8'h00;
            end
            default: ;
        endcase
    end

    assign tx_fire = tx_valid && tx_ready;

    always_comb begin
        tx_d       = tx_q;
        bcnt_d     = bcnt_q;
        wcnt_d     = wcnt_q;
        word_d     = word_q;
        word_vld_d = word_vld_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        to_cnt_d   = to_cnt_q;

        case (tx_q)
            T_IDLE: begin
                if (accept) begin
                    tx_d       = T_ID;
                    busy_d     = 1'b1;
                    cmd_d      = cmd_norm;
                    addr_d     = req_address;
                    cnt_d      = req_data_count;
                    bcnt_d     = 2'd0;
                    wcnt_d     = 24'd0;
                    word_vld_d = 1'b0;
                end
            end
            T_ID: begin
                if (tx_fire) begin
                    tx_d   = T_CMD;
                    bcnt_d = 2'd0;
                end
            end
            T_CMD: begin
                if (tx_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (cmd_q == CMD_PING) begin
                            tx_d     = T_WAIT;
                            to_cnt_d = 32'd0;
                        end else begin
                            tx_d = T_ADDR;
                        end
                    end
                end
            end
            T_ADDR: begin
                if (tx_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (cmd_q == CMD_WRITE && cnt_q != 24'd0) begin
                            tx_d   = T_DATA;
                            wcnt_d = 24'd0;
                        end else begin
                            tx_d     = T_WAIT;
                            to_cnt_d = 32'd0;
                        end
                    end
                end
            end
            T_DATA: begin
                if (wr_fire) begin
                    word_d     = wr_data;
                    word_vld_d = 1'b1;
                end
                if (tx_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        word_vld_d = 1'b0;
                        wcnt_d     = wcnt_q + 24'd1;
                        if (wcnt_q == cnt_q - 24'd1) begin
                            tx_d     = T_WAIT;
                            to_cnt_d = 32'd0;
                        end
                    end
                end
            end
            T_WAIT: begin
                // Each received byte restarts the response window.
                to_cnt_d = rx_fire ? 32'd0 : to_cnt_q + 32'd1;
            end
            default: tx_d = T_IDLE;
        endcase

        if (complete || timeout_hit) begin
            tx_d       = T_IDLE;
            busy_d     = 1'b0;
            bcnt_d     = 2'd0;
            word_vld_d = 1'b0;
            to_cnt_d   = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q       <= T_IDLE;
            bcnt_q     <= 2'd0;
            wcnt_q     <= 24'd0;
            word_q     <= 32'd0;
            word_vld_q <= 1'b0;
            cmd_q      <= 8'h00;
            addr_q     <= 32'd0;
            cnt_q      <= 24'd0;
            busy_q     <= 1'b0;
            to_cnt_q   <= 32'd0;
            err_to_q   <= 1'b0;
        end else begin
            tx_q       <= tx_d;
            bcnt_q     <= bcnt_d;
            wcnt_q     <= wcnt_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            to_cnt_q   <= to_cnt_d;
            err_to_q   <= timeout_hit;
        end
    end

endmodule
